// File: rtl/esop_eval_seq.sv
// esop_eval_seq: programmable sequential ESOP evaluator.
//
// A runtime-loaded cube memory is swept LANES cubes per cycle. Cube hits are
// XOR-accumulated (plus a constant term) and popcounted for each input vector.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cfg_we/addr/cube       cube memory write (accepted only while idle)
//   cfg_num_we/num/const   active cube count (clamped) and constant XOR term
//   cfg_busy               high whenever the evaluator is not idle
//   cfg_err                one-cycle pulse after a dropped config write
//   in_valid/ready/x       input vector handshake
//   out_valid/ready        result handshake
//   out_y, out_hits        ESOP value and number of hitting cubes
module esop_eval_seq #(
    parameter int unsigned N_IN      = 50,
    parameter int unsigned MAX_CUBES = 64,
    parameter int unsigned LANES     = 4,
    localparam int unsigned AW       = $clog2(MAX_CUBES),
    localparam int unsigned CW       = $clog2(MAX_CUBES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [2*N_IN-1:0] cfg_cube,
    input  logic              cfg_num_we,
    input  logic [CW-1:0]     cfg_num,
    input  logic              cfg_const,
    output logic              cfg_busy,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_y,
    output logic [CW-1:0]     out_hits
);

    // idx never wraps; SW leaves headroom for idx + LANES comparisons.
    localparam int unsigned IW = AW + 1;
    localparam int unsigned SW = AW + 2;

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                acc_q, acc_d;
    logic [CW-1:0]       hits_q, hits_d;
    logic [N_IN-1:0]     x_q, x_d;
    logic [CW-1:0]       num_q, num_d;
    logic                const_q, const_d;
    logic                cfg_err_q, cfg_err_d;

    logic [2*N_IN-1:0]   mem_q [MAX_CUBES];

    logic [SW-1:0]       lane_addr [LANES];
    logic [LANES-1:0]    lane_hit;
    logic [CW-1:0]       lane_cnt;

    function automatic logic cube_hit(input logic [2*N_IN-1:0] cube,
                                      input logic [N_IN-1:0]   x);
        logic hit;
        hit = 1'b1;
        for (int i = 0; i < int'(N_IN); i++) begin
            case (cube[2*i +: 2])
                2'b01:   if (!x[i]) hit = 1'b0;
                2'b10:   if (x[i]) hit = 1'b0;
                2'b11:   hit = 1'b0;
                default: ;
            endcase
        end
        return hit;
    endfunction

    // Lane evaluation; lanes at or beyond the active count are masked.
    always_comb begin
        lane_cnt = '0;
        lane_hit = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_addr[l] = SW'(idx_q) + SW'(l);
            lane_hit[l]  = (lane_addr[l] < SW'(num_q)) &&
                           cube_hit(mem_q[lane_addr[l][AW-1:0]], x_q);
            lane_cnt     = lane_cnt + CW'(lane_hit[l]);
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        hits_d    = hits_q;
        x_d       = x_q;
        num_d     = num_q;
        const_d   = const_q;
        cfg_err_d = (state_q != StIdle) && (cfg_we || cfg_num_we);
        // Config writes win over input acceptance.
        in_ready  = (state_q == StIdle) && !cfg_we && !cfg_num_we;

        case (state_q)
            StIdle: begin
                if (cfg_num_we) begin
                    num_d   = (cfg_num > CW'(MAX_CUBES)) ? CW'(MAX_CUBES) : cfg_num;
                    const_d = cfg_const;
                end
                if (in_valid && in_ready) begin
                    x_d     = in_x;
                    idx_d   = '0;
                    acc_d   = const_q;
                    hits_d  = '0;
                    state_d = StEval;
                end
            end
            StEval: begin
                acc_d  = acc_q ^ (^lane_hit);
                hits_d = hits_q + lane_cnt;
                idx_d  = idx_q + IW'(LANES);
                // Also covers num == 0: one fully masked cycle.
                if (SW'(idx_q) + SW'(LANES) >= SW'(num_q)) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            acc_q     <= 1'b0;
            hits_q    <= '0;
            x_q       <= '0;
            num_q     <= '0;
            const_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            hits_q    <= hits_d;
            x_q       <= x_d;
            num_q     <= num_d;
            const_q   <= const_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Cube storage is not reset; contents are masked while num is 0.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == StIdle)) mem_q[cfg_addr] <= cfg_cube;
    end

    assign out_valid = (state_q == StDone);
    assign cfg_busy  = (state_q != StIdle);
    assign cfg_err   = cfg_err_q;
    assign out_y     = acc_q;
    assign out_hits  = hits_q;

endmodule

// File: tb/tb_esop_eval_seq.sv
// tb_esop_eval_seq: directed self-checking bench for esop_eval_seq (default parameters).
module tb_esop_eval_seq;

    localparam int NI = 50;
    localparam int MC = 64;
    localparam int AW = 6;
    localparam int CW = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [2*NI-1:0]   cfg_cube = '0;
    logic              cfg_num_we = 1'b0;
    logic [CW-1:0]     cfg_num = '0;
    logic              cfg_const = 1'b0;
    logic              cfg_busy;
    logic              cfg_err;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NI-1:0]     in_x = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_y;
    logic [CW-1:0]     out_hits;

    int total = 0;
    int bad = 0;

    esop_eval_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_cube(cfg_cube),
        .cfg_num_we(cfg_num_we), .cfg_num(cfg_num), .cfg_const(cfg_const),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_hits(out_hits)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2*NI-1:0] lit(input int v, input logic [1:0] code);
        logic [2*NI-1:0] c;
        c = '0;
        c[2*v +: 2] = code;
        return c;
    endfunction

    function automatic logic [NI-1:0] mk_x(input logic b0, input logic b16, input logic b48);
        logic [NI-1:0] x;
        x = 50'h2AAAA5555C3C3;
        x[0] = b0;
        x[16] = b16;
        x[48] = b48;
        return x;
    endfunction

    task automatic write_cube(input int a, input logic [2*NI-1:0] c);
        cfg_we = 1'b1;
        cfg_addr = AW'(a);
        cfg_cube = c;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic write_num(input int n, input logic k);
        cfg_num_we = 1'b1;
        cfg_num = CW'(n);
        cfg_const = k;
        tick();
        cfg_num_we = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    // Called at a falling edge; accepts one vector and completes its handshake.
    task automatic run(input string tag, input logic [NI-1:0] x, input logic ey,
                       input int eh, input int elat);
        int cnt;
        in_x = x;
        in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        wait_valid(cnt);
        check({tag, "_latency"}, 64'(cnt), 64'(elat));
        check({tag, "_y"}, 64'(out_y), 64'(ey));
        check({tag, "_hits"}, 64'(out_hits), 64'(eh));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_clr"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int cnt;

        // Reset state
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_hits", 64'(out_hits), 64'd0);
        check("rst_busy", 64'(cfg_busy), 64'd0);
        check("rst_err", 64'(cfg_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Empty configuration, then constant term only
        run("empty", mk_x(1'b1, 1'b0, 1'b1), 1'b0, 0, 1);
        write_num(0, 1'b1);
        run("const1", mk_x(1'b0, 1'b1, 1'b0), 1'b1, 0, 1);

        // Single-literal cubes: c0 = +x16, c1 = -x48
        write_cube(0, lit(16, 2'b01));
        write_cube(1, lit(48, 2'b10));
        write_num(2, 1'b0);
        run("lit_11", mk_x(1'b0, 1'b1, 1'b1), 1'b1, 1, 1);
        run("lit_10", mk_x(1'b0, 1'b1, 1'b0), 1'b0, 2, 1);
        run("lit_00", mk_x(1'b0, 1'b0, 1'b0), 1'b1, 1, 1);

        // c2 all don't care, c3 = +x16 with a contradictory x5
        write_cube(2, '0);
        write_cube(3, lit(16, 2'b01) | lit(5, 2'b11));
        write_num(4, 1'b0);
        run("special", mk_x(1'b0, 1'b1, 1'b0), 1'b1, 3, 1);

        // c4..c8 = +x0, c9..c63 all don't care; num=9 masks 9..63
        for (int a = 4; a < 9; a++) write_cube(a, lit(0, 2'b01));
        for (int a = 9; a < MC; a++) write_cube(a, '0);
        write_num(9, 1'b0);
        run("mask_x0", mk_x(1'b1, 1'b1, 1'b0), 1'b0, 8, 3);
        run("mask_nx0", mk_x(1'b0, 1'b1, 1'b0), 1'b1, 3, 3);

        // num=70 clamps to 64 -> 16 EVAL cycles
        write_num(70, 1'b0);
        run("clamp", mk_x(1'b1, 1'b1, 1'b0), 1'b1, 63, 16);
        write_num(70, 1'b1);
        run("clamp_c1", mk_x(1'b0, 1'b1, 1'b0), 1'b1, 58, 16);

        // Backpressure
        write_num(2, 1'b0);
        in_x = mk_x(1'b0, 1'b1, 1'b1);
        in_valid = 1'b1;
        tick();
        in_x = mk_x(1'b0, 1'b1, 1'b0);
        wait_valid(cnt);
        check("bp_latency", 64'(cnt), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_y", 64'(out_y), 64'd1);
            check("bp_hits", 64'(out_hits), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_valid", 64'(out_valid), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run("bp_second", mk_x(1'b0, 1'b1, 1'b0), 1'b0, 2, 1);

        // Dropped config write during EVAL
        write_num(9, 1'b0);
        in_x = mk_x(1'b1, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("drop_busy", 64'(cfg_busy), 64'd1);
        cfg_we = 1'b1;
        cfg_addr = '0;
        cfg_cube = lit(16, 2'b10);
        tick();
        cfg_we = 1'b0;
        check("drop_err_pulse", 64'(cfg_err), 64'd1);
        tick();
        check("drop_err_clr", 64'(cfg_err), 64'd0);
        wait_valid(cnt);
        check("drop_valid", 64'(out_valid), 64'd1);
        check("drop_y", 64'(out_y), 64'd0);
        check("drop_hits", 64'(out_hits), 64'd8);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run("drop_after", mk_x(1'b1, 1'b1, 1'b0), 1'b0, 8, 3);

        // Reset mid-EVAL
        write_num(64, 1'b1);
        in_x = mk_x(1'b1, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(cfg_busy), 64'd0);
        check("mid_rst_hits", 64'(out_hits), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        run("post_rst_num0", mk_x(1'b1, 1'b1, 1'b0), 1'b0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/esop_eval_seq.md
# esop_eval_seq

Programmable, sequential ESOP (exclusive-sum-of-products) evaluator. It replaces a fixed combinational XOR-of-ANDs network with a runtime-loadable cube memory that is swept `LANES` cubes per cycle and XOR-accumulated. It sits behind the benchmark/synthesis flow as a hardware checker: the host loads a cube list, then streams input vectors and collects one parity bit per vector, with valid/ready on both sides.

## Interface
Parameters:
- `N_IN`, default 50: number of primary inputs (variables).
- `MAX_CUBES`, default 64: cube memory depth. Must be a multiple of `LANES`.
- `LANES`, default 4: cubes evaluated per cycle. Must be ≥1.

Ports (`AW = $clog2(MAX_CUBES)`, `CW = $clog2(MAX_CUBES+1)`):
- `clk  in  1`  sole clock; all logic is on the rising edge.
- `rst_n  in  1`  asynchronous, active-low reset.
- `cfg_we  in  1`  write `cfg_cube` into cube memory at `cfg_addr`.
- `cfg_addr  in  AW`  cube memory address.
- `cfg_cube  in  2*N_IN`  cube encoding; bits `[2i+1:2i]` belong to variable i:
  - 00 = don't care
  - 01 = positive literal
  - 10 = negative literal
  - 11 = contradiction (cube never hits)
- `cfg_num_we  in  1`  load `cfg_num` and `cfg_const`.
- `cfg_num  in  CW`  active cube count. Values above `MAX_CUBES` clamp to `MAX_CUBES`.
- `cfg_const  in  1`  constant XOR term (the ESOP "1" cube).
- `cfg_busy  out  1`  high whenever state ≠ IDLE.
- `cfg_err  out  1`  one-cycle pulse when a config write is dropped.
- `in_valid  in  1` / `in_ready  out  1` / `in_x  in  N_IN`  input vector handshake.
- `out_valid  out  1` / `out_ready  in  1`  result handshake.
- `out_y  out  1`  ESOP value.
- `out_hits  out  CW`  number of active cubes that evaluated to 1.

## Operation
- **Cube hit rule:** a cube hits iff no variable is 11, every 01 variable has `x=1`, and every 10 variable has `x=0`.
- **Result:** `out_y = cfg_const ^ (XOR of hits over addresses 0..num-1)`. `out_hits` is the popcount of those hits.
- **FSM states:** IDLE, EVAL, DONE.
- **IDLE:**
  - `in_ready = ~cfg_we & ~cfg_num_we`; config writes take priority over input acceptance.
  - On `in_valid & in_ready`: latch `in_x`, set `idx=0`, `acc=const`, `hits=0`, go to EVAL.
- **EVAL, each cycle:**
  - Evaluate addresses `idx..idx+LANES-1`; lanes with address ≥ num are masked to 0.
  - Update `acc ^= XOR(lane hits)`, `hits += popcount(lane hits)`, `idx += LANES`.
  - When `idx+LANES >= num`, go to DONE.
  - `num=0` still takes exactly one EVAL cycle, with all lanes masked.
- **DONE:**
  - `out_valid=1`; `out_y` and `out_hits` are stable.
  - On `out_ready`, go to IDLE.
  - No new input is accepted until the handshake completes.
- **Config writes:**
  - Accepted only in IDLE and take effect at the next edge.
  - `cfg_we` or `cfg_num_we` in EVAL or DONE is dropped: pulse `cfg_err` the next cycle; memory and count are unchanged.
  - The in-flight result always reflects the configuration present at acceptance.
- **Widths:** `idx` is AW+1 bits and never wraps. Accumulators are sized so `hits ≤ MAX_CUBES` cannot overflow.

## Timing
- **Reset values:**
  - state=IDLE, `in_ready=1`, `out_valid=0`, `out_y=0`, `out_hits=0`, `cfg_busy=0`, `cfg_err=0`.
  - `num=0`, `const=0`.
  - Cube memory is not reset; it is irrelevant while `num=0`.
- **Latency:** acceptance at edge k gives `out_valid` high after edge `k + max(1, ceil(num/LANES))`.
- **Throughput:** one vector per `max(1, ceil(num/LANES)) + 1` cycles with `out_ready` held high.
- **Reset mid-operation:** asynchronous assertion forces IDLE and clears outputs immediately. The pending vector is discarded.
- **`in_valid` behaviour:** may drop before acceptance with no effect. `in_x` is sampled only on the accept edge.

## Test plan
- **Empty configuration:** after reset with `num=0`, `const=0`, send any `in_x` → `out_valid` 1 cycle after accept, `out_y=0`, `out_hits=0`. Then load `const=1` → `out_y=1`.
- **Single-literal cubes:**
  - Load cube0 = positive x16 (bits[33:32]=01) and cube1 = negative x48 (bits[97:96]=10); set `num=2`.
  - `x16=1`, `x48=1` → `out_y=1`, hits=1.
  - `x16=1`, `x48=0` → `out_y=0`, hits=2.
- **Special cubes:** an all-00 cube always hits. A cube containing any 11 never hits, including when `in_x` satisfies all its other literals.
- **Count masking and latency:**
  - `num=9`, `LANES=4`, addresses 9..63 filled with all-don't-care cubes → those addresses never contribute.
  - `out_valid` exactly 3 cycles after accept.
  - `num=70` clamps to 64, giving 16 EVAL cycles.
- **Backpressure:** `out_ready` held low for 5 cycles → `out_y` and `out_hits` stable, `in_ready=0`. A second vector is accepted only after the handshake and its result is correct.
- **Dropped config write and reset mid-operation:**
  - `cfg_we` asserted in EVAL → `cfg_err` pulses once; the result and a subsequent evaluation match the old memory.
  - `rst_n` low mid-EVAL → `out_valid=0` and `in_ready=1` after release; `num` is 0.
